fsm_payout: RTL

FSM_PAYOUT -- requirements
Module: fsm_payout

---
 rtl/fsm_sell_pkg.sv | 29 ++
 rtl/ack_timer.sv | 29 ++
 rtl/fsm_payout.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fsm_sell_pkg.sv
// fsm_sell_pkg: state encodings and constants shared by the
// vending seller and payout FSMs.
package fsm_sell_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VEND    = 3'd1,
    ST_PAY_REQ = 3'd2,
    ST_PAY_GAP = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAULT   = 3'd5
  } pay_state_t;

  localparam int ACK_TIMEOUT_DEF = 15;
  localparam int UNIT_W_DEF      = 2;

  // coin values in jiao (0.1 yuan)
  localparam int COIN_HALF_JIAO = 5;
  localparam int COIN_ONE_JIAO  = 10;

  // a sale flagged with change always owes at least one coin
  function automatic int units_owed(
    input logic cf,
    input int   cu
  );
    return !cf ? 0 : ((cu == 0) ? 1 : cu);
  endfunction

endpackage

// File: rtl/ack_timer.sv
// ack_timer: counts hopper wait cycles and flags the cycle
// in which the wait limit is reached.
module ack_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign expired = enable && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fsm_payout.sv
// fsm_payout: vends one item per sale request, pays change
// from the hopper coin by coin, buffers one pending sale.
module fsm_payout
  import fsm_sell_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int UNIT_W      = UNIT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sell_flag,
  input  logic              change_flag,
  input  logic [UNIT_W-1:0] change_units,
  input  logic              coin_ack,
  output logic              item_out,
  output logic              coin_req,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              fault
);

  pay_state_t        state, state_n;
  logic [UNIT_W-1:0] units, units_n;
  logic [UNIT_W-1:0] pend_units, pend_units_n;
  logic [UNIT_W-1:0] req_units;
  logic              pend_vld, pend_vld_n;
  logic              ovf_n;
  logic              expired;
  logic              direct;

  assign req_units =
    UNIT_W'(units_owed(change_flag, int'(change_units)));

  // an idle unit with an empty slot launches the request itself
  assign direct = (state == ST_IDLE) && !pend_vld;

  ack_timer #(
    .LIMIT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (state != ST_PAY_REQ),
    .enable  ((state == ST_PAY_REQ) && !coin_ack),
    .expired (expired)
  );

  always_comb begin
    state_n      = state;
    units_n      = units;
    pend_vld_n   = pend_vld;
    pend_units_n = pend_units;
    ovf_n        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pend_vld) begin
          state_n    = ST_VEND;
          units_n    = pend_units;
          pend_vld_n = 1'b0;
        end else if (sell_flag) begin
          state_n = ST_VEND;
          units_n = req_units;
        end
      end
      ST_VEND: begin
        state_n = (units != '0) ? ST_PAY_REQ : ST_DONE;
      end
      ST_PAY_REQ: begin
        if (coin_ack) begin
          state_n = ST_PAY_GAP;
          if (units != '0) begin
            units_n = units - 1'b1;
          end
        end else if (expired) begin
          state_n = ST_FAULT;
        end
      end
      ST_PAY_GAP: begin
        state_n = (units != '0) ? ST_PAY_REQ : ST_DONE;
      end
      ST_DONE: begin
        if (pend_vld) begin
          state_n    = ST_VEND;
          units_n    = pend_units;
          pend_vld_n = 1'b0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_FAULT: begin
        state_n = ST_FAULT;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    // a slot freed this cycle is free for the incoming request
    if (sell_flag && state != ST_FAULT && !direct) begin
      if (!pend_vld_n) begin
        pend_vld_n   = 1'b1;
        pend_units_n = req_units;
      end else begin
        ovf_n = 1'b1;
      end
    end
    if (state_n == ST_FAULT) begin
      pend_vld_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      units      <= '0;
      pend_vld   <= 1'b0;
      pend_units <= '0;
      item_out   <= 1'b0;
      coin_req   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      units      <= units_n;
      pend_vld   <= pend_vld_n;
      pend_units <= pend_units_n;
      item_out   <= (state_n == ST_VEND);
      coin_req   <= (state_n == ST_PAY_REQ);
      busy       <= (state_n != ST_IDLE);
      done       <= (state_n == ST_DONE);
      overflow   <= ovf_n;
      fault      <= (state_n == ST_FAULT);
    end
  end

endmodule
